// File: rtl/usb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_ctrl_pkg
// Description : Shared types and default constants for the USB controller
//               transmit path. This file defines the transmit scheduler state
//               encoding, the default turnaround and timeout values, and the
//               per-requester transmit buffer size.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_ctrl_pkg;

    // Each requester owns one transmit buffer of this size.
    localparam int USB_BUF_BYTES     = 512;

    // Default scheduler tuning values.
    localparam int TX_TURNAROUND_DEF = 2;
    localparam int TX_TIMEOUT_DEF    = 8192;

    // Transmit scheduler states. The encoding is explicit and 3 bits wide.
    typedef enum logic [2:0] {
        TX_IDLE     = 3'd0,
        TX_WAIT_BUS = 3'd1,
        TX_START    = 3'd2,
        TX_XFER     = 3'd3,
        TX_DONE     = 3'd4,
        TX_ABORT    = 3'd5
    } tx_sched_state_t;

endpackage : usb_ctrl_pkg
`default_nettype wire

// File: rtl/usb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : usb_rr_arbiter
// Description : Purely combinational round-robin pick. The winner is the
//               first set request bit after last_ptr, wrapping around. The
//               caller holds all pointer state.
// Ports       : req      - request vector
//               last_ptr - index of the most recently served requester
//               any_req  - at least one request bit is set
//               grant    - one-hot winner (all zero when no request)
//               idx      - binary index of the winner
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_ptr,
    output logic                       any_req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int c_IDX_W = $clog2(NUM_REQ);

    int w_dist;
    int w_best;
    int w_lp;

    assign any_req = |req;

    // Each requester gets a distance from last_ptr in 1..NUM_REQ; the
    // requester at last_ptr itself sits at NUM_REQ, i.e. lowest priority.
    // The smallest distance among the set bits wins.
    always_comb begin
        w_lp   = int'(last_ptr);
        w_best = NUM_REQ + 1;
        w_dist = 0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i > w_lp) ? (i - w_lp) : (i + NUM_REQ - w_lp);
            if (req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                idx    = c_IDX_W'(i);
            end
        end
    end

    assign grant = any_req ? (NUM_REQ'(1) << idx) : '0;

endmodule : usb_rr_arbiter
`default_nettype wire

// File: rtl/usb_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_scheduler
// Description : Round-robin transmit scheduler in front of the ULPI transmit
//               path. It grants one requester, waits for the PHY to release
//               the bus for TURNAROUND cycles, and then issues a one-cycle
//               shift_out start pulse. It then waits for stp (done) and
//               aborts on PHY takeover (dir) or on timeout (err).
// Ports       : clk       - system clock
//               n_rst     - asynchronous active-low reset
//               req       - level request per requester
//               grant     - one-hot grant, held until done/err
//               done      - one-cycle completion pulse per requester
//               err       - one-cycle abort pulse per requester
//               dir       - PHY owns the bus (already synchronous to clk)
//               stp       - end of transmit from usb_state_machine
//               shift_out - one-cycle transmit start pulse
//               buf_sel   - transmit buffer mux select
//               busy      - scheduler is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_scheduler
    import usb_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TURNAROUND     = TX_TURNAROUND_DEF,
    parameter int TIMEOUT_CYCLES = TX_TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         err,
    input  logic                       dir,
    input  logic                       stp,
    output logic                       shift_out,
    output logic [$clog2(NUM_REQ)-1:0] buf_sel,
    output logic                       busy
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_TA_W  = $clog2(TURNAROUND + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [c_TA_W-1:0]  c_TA_DONE = c_TA_W'(TURNAROUND);
    localparam logic [c_TO_W-1:0]  c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_PTR_RST = c_IDX_W'(NUM_REQ - 1);

    tx_sched_state_t     r_state;
    logic [c_IDX_W-1:0]  r_last_ptr;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_done;
    logic [NUM_REQ-1:0]  r_err;
    logic [c_IDX_W-1:0]  r_buf_sel;
    logic                r_shift_out;
    logic                r_busy;
    logic [c_TA_W-1:0]   r_ta_cnt;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                r_abort_adv;

    logic                w_any_req;
    logic [NUM_REQ-1:0]  w_arb_grant;
    logic [c_IDX_W-1:0]  w_arb_idx;
    logic                w_req_held;

    usb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req      (req),
        .last_ptr (r_last_ptr),
        .any_req  (w_any_req),
        .grant    (w_arb_grant),
        .idx      (w_arb_idx)
    );

    // The granted requester is still asking for the bus.
    assign w_req_held = |(req & r_grant);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= TX_IDLE;
            r_last_ptr  <= c_PTR_RST;
            r_grant     <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_buf_sel   <= '0;
            r_shift_out <= 1'b0;
            r_busy      <= 1'b0;
            r_ta_cnt    <= '0;
            r_to_cnt    <= '0;
            r_abort_adv <= 1'b0;
        end else begin
            // Pulse outputs default low and are raised for a single cycle.
            r_done      <= '0;
            r_err       <= '0;
            r_shift_out <= 1'b0;

            case (r_state)
                TX_IDLE: begin
                    if (w_any_req) begin
                        r_grant   <= w_arb_grant;
                        r_buf_sel <= w_arb_idx;
                        r_ta_cnt  <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= TX_WAIT_BUS;
                    end
                end

                TX_WAIT_BUS: begin
                    // A withdrawn request leaves quietly and keeps its place.
                    if (!w_req_held) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= TX_IDLE;
                    end else if (r_ta_cnt == c_TA_DONE) begin
                        // shift_out is registered on entry so it is high
                        // for exactly the START cycle.
                        r_shift_out <= 1'b1;
                        r_state     <= TX_START;
                    end else if (dir) begin
                        r_ta_cnt <= '0;
                    end else begin
                        r_ta_cnt <= r_ta_cnt + 1'b1;
                    end
                end

                TX_START: begin
                    r_to_cnt <= '0;
                    r_state  <= TX_XFER;
                end

                TX_XFER: begin
                    if (stp) begin
                        r_state <= TX_DONE;
                    end else if (dir) begin
                        // PHY takeover: the victim keeps its priority.
                        r_abort_adv <= 1'b0;
                        r_state     <= TX_ABORT;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_abort_adv <= 1'b1;
                        r_state     <= TX_ABORT;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                TX_DONE: begin
                    r_done     <= r_grant;
                    r_last_ptr <= r_buf_sel;
                    r_grant    <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= TX_IDLE;
                end

                TX_ABORT: begin
                    r_err <= r_grant;
                    if (r_abort_adv) begin
                        r_last_ptr <= r_buf_sel;
                    end
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= TX_IDLE;
                end

                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign done      = r_done;
    assign err       = r_err;
    assign shift_out = r_shift_out;
    assign buf_sel   = r_buf_sel;
    assign busy      = r_busy;

endmodule : usb_tx_scheduler
`default_nettype wire

// File: tb/tb_usb_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_tx_scheduler
// Description : Self-checking bench for usb_tx_scheduler. It runs randomized
//               transactions (idle gaps, bus-busy turnaround, withdrawn
//               requests, stp completion, PHY takeover and timeout aborts)
//               and compares them with a transaction-level reference model.
//               It also includes a directed asynchronous reset in mid-transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_scheduler;

    localparam int NUM_REQ        = 3;
    localparam int TURNAROUND     = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int IDX_W          = $clog2(NUM_REQ);

    logic               clk   = 1'b0;
    logic               n_rst = 1'b0;
    logic [NUM_REQ-1:0] req   = '0;
    logic               dir   = 1'b0;
    logic               stp   = 1'b0;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] err;
    logic               shift_out;
    logic [IDX_W-1:0]   buf_sel;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;
    int m_last  = NUM_REQ - 1;   // model: most recently served requester

    usb_tx_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .TURNAROUND     (TURNAROUND),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .req       (req),
        .grant     (grant),
        .done      (done),
        .err       (err),
        .dir       (dir),
        .stp       (stp),
        .shift_out (shift_out),
        .buf_sel   (buf_sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference arbitration: first set bit after the last served index.
    function automatic int pick(input logic [NUM_REQ-1:0] r, input int lp);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(lp + k) % NUM_REQ]) return (lp + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic expect_outs(input string tag, input logic [NUM_REQ-1:0] g, input logic b,
                               input logic so, input logic [NUM_REQ-1:0] dn,
                               input logic [NUM_REQ-1:0] er, input int bs);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".shift_out"}, 32'(shift_out), 32'(so));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".err"}, 32'(err), 32'(er));
        if (bs >= 0) chk({tag, ".buf_sel"}, 32'(buf_sel), 32'(bs));
    endtask

    task automatic run_txn();
        logic [NUM_REQ-1:0] r;
        int  win;
        int  cyc;
        int  outcome;   // 0 running, 1 done, 2 abort (keep ptr), 3 abort (advance)
        int  k;
        bit  started;
        bit  withdrawn;
        bit  all_low;
        bit  s;
        bit  d;
        bit  hist[$];

        repeat ($urandom_range(0, 2)) begin
            req = '0;
            dir = 1'($urandom_range(0, 1));
            stp = 1'($urandom_range(0, 1));
            step();
            expect_outs("idle", '0, 1'b0, 1'b0, '0, '0, -1);
        end

        // Arbitration edge.
        r   = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
        win = pick(r, m_last);
        req = r;
        dir = 1'($urandom_range(0, 1));
        stp = 1'($urandom_range(0, 1));
        step();
        expect_outs("arb", oh(win), 1'b1, 1'b0, '0, '0, win);

        // Bus wait: start on the first edge preceded by TURNAROUND low dir
        // samples in a row, unless the request is withdrawn first.
        started   = 1'b0;
        withdrawn = 1'b0;
        cyc       = 0;
        hist.delete();
        while (!started && !withdrawn) begin
            dir = (cyc > 30) ? 1'b0 : ($urandom_range(0, 3) == 0);
            req = NUM_REQ'($urandom) | oh(win);
            if ($urandom_range(0, 24) == 0) req[win] = 1'b0;
            stp = 1'($urandom_range(0, 1));
            all_low = (hist.size() >= TURNAROUND);
            for (int j = 0; j < TURNAROUND && j < hist.size(); j++) begin
                if (hist[hist.size() - 1 - j]) all_low = 1'b0;
            end
            step();
            if (!req[win]) begin
                withdrawn = 1'b1;
                expect_outs("withdraw", '0, 1'b0, 1'b0, '0, '0, -1);
            end else if (all_low) begin
                started = 1'b1;
                expect_outs("start", oh(win), 1'b1, 1'b1, '0, '0, win);
            end else begin
                hist.push_back(dir);
                expect_outs("wait", oh(win), 1'b1, 1'b0, '0, '0, win);
            end
            cyc++;
            if (cyc > 200) begin
                chk("wait_bound", 32'(cyc), 32'(0));
                return;
            end
        end
        if (withdrawn) return;

        // START -> XFER: request is ignored from here on.
        req = NUM_REQ'($urandom);
        dir = 1'($urandom_range(0, 1));
        stp = 1'($urandom_range(0, 1));
        step();
        expect_outs("xfer0", oh(win), 1'b1, 1'b0, '0, '0, win);

        outcome = 0;
        k       = 0;
        while (outcome == 0) begin
            s   = ($urandom_range(0, 11) == 0);
            d   = ($urandom_range(0, 19) == 0);
            stp = s;
            dir = d;
            req = NUM_REQ'($urandom);
            step();
            if (s)                            outcome = 1;
            else if (d)                       outcome = 2;
            else if (k == TIMEOUT_CYCLES - 1) outcome = 3;
            expect_outs("xfer", oh(win), 1'b1, 1'b0, '0, '0, win);
            k++;
        end

        // Completion edge: pulse and grant release.
        stp = 1'($urandom_range(0, 1));
        dir = 1'($urandom_range(0, 1));
        req = NUM_REQ'($urandom);
        step();
        if (outcome == 1) begin
            expect_outs("done", '0, 1'b0, 1'b0, oh(win), '0, -1);
            m_last = win;
        end else begin
            expect_outs(outcome == 2 ? "abort_dir" : "abort_to", '0, 1'b0, 1'b0, '0, oh(win), -1);
            if (outcome == 3) m_last = win;
        end
    endtask

    initial begin
        // Power-on reset.
        n_rst = 1'b0;
        step();
        step();
        expect_outs("rst_hold", '0, 1'b0, 1'b0, '0, '0, 0);
        n_rst = 1'b1;
        step();
        expect_outs("rst_idle", '0, 1'b0, 1'b0, '0, '0, 0);

        // Directed: requester 2 alone, dir low, then async reset mid-XFER.
        req = 3'b100;
        dir = 1'b0;
        stp = 1'b0;
        step();
        expect_outs("d_arb", 3'b100, 1'b1, 1'b0, '0, '0, 2);
        repeat (TURNAROUND) begin
            step();
            expect_outs("d_wait", 3'b100, 1'b1, 1'b0, '0, '0, 2);
        end
        step();
        expect_outs("d_start", 3'b100, 1'b1, 1'b1, '0, '0, 2);
        step();
        expect_outs("d_xfer", 3'b100, 1'b1, 1'b0, '0, '0, 2);
        #2;
        n_rst = 1'b0;
        #1;
        expect_outs("d_async_rst", '0, 1'b0, 1'b0, '0, '0, 0);
        step();
        req   = '0;
        n_rst = 1'b1;
        step();
        expect_outs("d_post_rst", '0, 1'b0, 1'b0, '0, '0, 0);
        m_last = NUM_REQ - 1;

        // Randomized transactions against the reference model.
        repeat (300) run_txn();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_usb_tx_scheduler
`default_nettype wire
